// File: rtl/coherence_arbiter.sv
// coherence_arbiter: round-robin sequencer sharing one MSI directory between two cache-block FSMs.
// Grants one request at a time, relays directory fetch/invalidate commands and acks the requester.
module coherence_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] reqWriteBack,
  input  logic [1:0] reqWriteMiss,
  input  logic [1:0] reqReadMiss,
  output logic [1:0] reqAck,
  output logic       dirWriteBack,
  output logic       dirWriteMiss,
  output logic       dirReadMiss,
  output logic       dirRequester,
  input  logic       dirFetch,
  input  logic       dirInvalidate,
  input  logic       dirDataValueReply,
  input  logic [1:0] dirSharers,
  output logic [1:0] cacheFetch,
  output logic [1:0] cacheInvalidate,
  input  logic [1:0] cacheDone,
  output logic       busy,
  output logic       timeout
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ISSUE      = 3'd1;
  localparam logic [2:0] WAIT_DIR   = 3'd2;
  localparam logic [2:0] CMD        = 3'd3;
  localparam logic [2:0] WAIT_CACHE = 3'd4;
  localparam logic [2:0] COMPLETE   = 3'd5;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state_reg, state_next;
  logic          grant_reg, grant_next;
  logic          last_grant_reg, last_grant_next;
  logic [2:0]    msg_reg, msg_next;  // one-hot {writeBack, writeMiss, readMiss}
  logic [1:0]    target_reg, target_next;
  logic          fetch_reg, fetch_next;
  logic          inv_reg, inv_next;
  logic          reply_reg, reply_next;
  logic          timeout_reg, timeout_next;
  logic [CW-1:0] count_reg, count_next;

  logic [1:0] pending;
  logic       sel;
  logic       dir_pulse, waiting, progress, expired;
  logic [1:0] sharer_target, remaining;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cache
    assign pending[gi] = reqWriteBack[gi] | reqWriteMiss[gi] | reqReadMiss[gi];
    assign reqAck[gi]  = (state_reg == COMPLETE) && (grant_reg == 1'(gi));
  end

  // Contention goes to whoever was not served last; otherwise the lone requester.
  assign sel = (&pending) ? ~last_grant_reg : pending[1];

  assign dir_pulse     = dirFetch | dirInvalidate | dirDataValueReply;
  assign waiting       = (state_reg == WAIT_DIR) || (state_reg == WAIT_CACHE);
  assign progress      = dir_pulse | (|cacheDone);
  assign expired       = waiting && !progress && (count_reg == CW'(TIMEOUT_CYCLES - 1));
  assign sharer_target = dirSharers & ~(2'b01 << grant_reg);
  assign remaining     = target_reg & ~cacheDone;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    msg_next        = msg_reg;
    target_next     = target_reg;
    fetch_next      = fetch_reg;
    inv_next        = inv_reg;
    reply_next      = reply_reg;
    timeout_next    = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (|pending) begin
          grant_next = sel;
          if (reqWriteBack[sel])      msg_next = 3'b100;
          else if (reqWriteMiss[sel]) msg_next = 3'b010;
          else                        msg_next = 3'b001;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = msg_reg[2] ? COMPLETE : WAIT_DIR;
      WAIT_DIR: begin
        if (dirFetch || dirInvalidate) begin
          target_next = sharer_target;
          fetch_next  = dirFetch;
          inv_next    = dirInvalidate;
          if (dirDataValueReply) reply_next = 1'b1;
          if (sharer_target != 2'b00)                state_next = CMD;
          else if (reply_reg || dirDataValueReply)   state_next = COMPLETE;
        end else if (dirDataValueReply) begin
          state_next = COMPLETE;
        end else if (expired) begin
          timeout_next = 1'b1;
          state_next   = COMPLETE;
        end
      end
      CMD: state_next = WAIT_CACHE;
      WAIT_CACHE: begin
        target_next = remaining;
        if (dirDataValueReply) reply_next = 1'b1;
        if (remaining == 2'b00) begin
          state_next = (reply_reg || dirDataValueReply) ? COMPLETE : WAIT_DIR;
        end else if (expired) begin
          timeout_next = 1'b1;
          state_next   = COMPLETE;
        end
      end
      COMPLETE: begin
        last_grant_next = grant_reg;
        reply_next      = 1'b0;
        target_next     = 2'b00;
        fetch_next      = 1'b0;
        inv_next        = 1'b0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The stall counter only runs while parked in a wait state with nothing happening.
  always_comb begin
    if ((state_next != state_reg) || progress || !waiting) count_next = '0;
    else                                                   count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      msg_reg        <= 3'b000;
      target_reg     <= 2'b00;
      fetch_reg      <= 1'b0;
      inv_reg        <= 1'b0;
      reply_reg      <= 1'b0;
      timeout_reg    <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      msg_reg        <= msg_next;
      target_reg     <= target_next;
      fetch_reg      <= fetch_next;
      inv_reg        <= inv_next;
      reply_reg      <= reply_next;
      timeout_reg    <= timeout_next;
      count_reg      <= count_next;
    end
  end

  assign busy            = (state_reg != IDLE);
  assign dirRequester    = busy & grant_reg;
  assign dirWriteBack    = (state_reg == ISSUE) & msg_reg[2];
  assign dirWriteMiss    = (state_reg == ISSUE) & msg_reg[1];
  assign dirReadMiss     = (state_reg == ISSUE) & msg_reg[0];
  assign cacheFetch      = ((state_reg == CMD) && fetch_reg) ? target_reg : 2'b00;
  assign cacheInvalidate = ((state_reg == CMD) && inv_reg) ? target_reg : 2'b00;
  assign timeout         = timeout_reg;
endmodule

// File: tb/tb_coherence_arbiter.sv
// Bench for coherence_arbiter: vector table, directed multi-cycle corner sequences and a
// randomized run scored against a transaction-level model of arbitration and completion.
module tb_coherence_arbiter;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] reqWriteBack = '0, reqWriteMiss = '0, reqReadMiss = '0;
  logic [1:0] reqAck;
  logic       dirWriteBack, dirWriteMiss, dirReadMiss, dirRequester;
  logic       dirFetch = 1'b0, dirInvalidate = 1'b0, dirDataValueReply = 1'b0;
  logic [1:0] dirSharers = '0, cacheDone = '0;
  logic [1:0] cacheFetch, cacheInvalidate;
  logic       busy, timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] wb;
    logic [1:0] wm;
    logic [1:0] rm;
    int         gnt;
    logic [2:0] msg;
  } vec_t;
  vec_t vecs [8];

  // random-phase model state
  logic [2:0] rq [2];
  int         cool [2];
  bit         idle_m, ack_prev, active, exp_issue;
  int         g, cur, last_m, mode, ack_due, dir_at, done_at, cmd_due, n_acks, n_grants;
  logic [1:0] fi, sh, tgt, cmd_f, cmd_i, exp_ack;
  logic [2:0] exp_msg;
  // directed-phase scratch
  int         n_b, both_b;
  logic [1:0] acks_b [2];
  logic       rflag;

  coherence_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clock(clock), .resetn(resetn),
    .reqWriteBack(reqWriteBack), .reqWriteMiss(reqWriteMiss), .reqReadMiss(reqReadMiss),
    .reqAck(reqAck),
    .dirWriteBack(dirWriteBack), .dirWriteMiss(dirWriteMiss), .dirReadMiss(dirReadMiss),
    .dirRequester(dirRequester),
    .dirFetch(dirFetch), .dirInvalidate(dirInvalidate), .dirDataValueReply(dirDataValueReply),
    .dirSharers(dirSharers),
    .cacheFetch(cacheFetch), .cacheInvalidate(cacheInvalidate), .cacheDone(cacheDone),
    .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    reqWriteBack = '0; reqWriteMiss = '0; reqReadMiss = '0;
    dirFetch = 1'b0; dirInvalidate = 1'b0; dirDataValueReply = 1'b0;
    dirSharers = '0; cacheDone = '0;
  endtask

  function automatic logic [11:0] outs();
    return {reqAck, dirWriteBack, dirWriteMiss, dirReadMiss, dirRequester,
            cacheFetch, cacheInvalidate, busy, timeout};
  endfunction

  function automatic logic [2:0] prio(input logic [2:0] r);
    if (r[2]) return 3'b100;
    if (r[1]) return 3'b010;
    return 3'b001;
  endfunction

  initial begin
    // lastGrant is 0 after the first directed read miss
    vecs[0] = '{wb: 2'b10, wm: 2'b10, rm: 2'b10, gnt: 1, msg: 3'b100};
    vecs[1] = '{wb: 2'b00, wm: 2'b11, rm: 2'b00, gnt: 0, msg: 3'b010};
    vecs[2] = '{wb: 2'b01, wm: 2'b00, rm: 2'b11, gnt: 1, msg: 3'b001};
    vecs[3] = '{wb: 2'b00, wm: 2'b01, rm: 2'b11, gnt: 0, msg: 3'b010};
    vecs[4] = '{wb: 2'b11, wm: 2'b00, rm: 2'b00, gnt: 1, msg: 3'b100};
    vecs[5] = '{wb: 2'b00, wm: 2'b10, rm: 2'b00, gnt: 1, msg: 3'b010};
    vecs[6] = '{wb: 2'b10, wm: 2'b00, rm: 2'b01, gnt: 0, msg: 3'b001};
    vecs[7] = '{wb: 2'b00, wm: 2'b00, rm: 2'b10, gnt: 1, msg: 3'b001};

    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", outs(), 12'h000);
    resetn = 1'b1;

    // cache 0 read miss, reply one cycle after the directory message
    reqReadMiss = 2'b01;
    step();
    check("rm_dir_msg", {dirWriteBack, dirWriteMiss, dirReadMiss}, 3'b001);
    check("rm_requester", dirRequester, 1'b0);
    step();
    dirDataValueReply = 1'b1;
    check("rm_no_early_ack", reqAck, 2'b00);
    step();
    dirDataValueReply = 1'b0;
    check("rm_ack", reqAck, 2'b01);
    reqReadMiss = 2'b00;
    step();
    check("rm_busy_low", busy, 1'b0);
    $display("read miss: cache 0 acked at cycle 3");

    for (int k = 0; k < 8; k++) begin
      reqWriteBack = vecs[k].wb; reqWriteMiss = vecs[k].wm; reqReadMiss = vecs[k].rm;
      step();
      check($sformatf("vec%0d_msg", k), {dirWriteBack, dirWriteMiss, dirReadMiss}, vecs[k].msg);
      check($sformatf("vec%0d_requester", k), dirRequester, vecs[k].gnt);
      if (vecs[k].msg != 3'b100) begin
        step();
        dirDataValueReply = 1'b1;
      end
      step();
      dirDataValueReply = 1'b0;
      check($sformatf("vec%0d_ack", k), reqAck, 2'b01 << vecs[k].gnt);
      $display("vec %0d: grant %0d msg %b ack %b", k, dirRequester, vecs[k].msg, reqAck);
      reqWriteBack = '0; reqWriteMiss = '0; reqReadMiss = '0;
      step();
      check($sformatf("vec%0d_idle", k), busy, 1'b0);
    end

    // both caches write-miss continuously, directory replies immediately
    reqWriteMiss = 2'b11; n_b = 0; both_b = 0; rflag = 1'b0;
    acks_b[0] = '0; acks_b[1] = '0;
    for (int c = 0; c < 30; c++) begin
      step();
      dirDataValueReply = rflag;
      rflag = dirWriteMiss;
      if (reqAck == 2'b11) both_b++;
      if (reqAck != 2'b00) begin
        if (n_b < 2) acks_b[n_b] = reqAck;
        n_b++;
        reqWriteMiss = reqWriteMiss & ~reqAck;
      end
    end
    dirDataValueReply = 1'b0;
    check("rr_ack_count", n_b, 2);
    check("rr_first_ack", acks_b[0], 2'b01);
    check("rr_second_ack", acks_b[1], 2'b10);
    check("rr_never_both", both_b, 0);
    $display("round robin: acks %b then %b", acks_b[0], acks_b[1]);

    // cache 1 write miss, fetch+invalidate to cache 0
    reqWriteMiss = 2'b10;
    step();
    check("fi_dir_msg", {dirWriteMiss, dirRequester}, 2'b11);
    step();
    dirFetch = 1'b1; dirInvalidate = 1'b1; dirSharers = 2'b11;
    step();
    dirFetch = 1'b0; dirInvalidate = 1'b0; dirSharers = 2'b00;
    check("fi_cmd", {cacheFetch, cacheInvalidate}, 4'b0101);
    step(); step(); step();
    cacheDone = 2'b01;
    step();
    cacheDone = 2'b00;
    check("fi_wait_no_ack", {busy, reqAck}, 3'b100);
    dirDataValueReply = 1'b1;
    step();
    dirDataValueReply = 1'b0;
    check("fi_ack", reqAck, 2'b10);
    reqWriteMiss = 2'b00;
    step();
    $display("fetch/invalidate: cache 1 acked");

    // invalidate naming only the requester: no command, wait for reply
    reqReadMiss = 2'b01;
    step();
    step();
    dirInvalidate = 1'b1; dirSharers = 2'b01;
    step();
    dirInvalidate = 1'b0; dirSharers = 2'b00;
    for (int c = 0; c < 4; c++) begin
      check("self_inv_quiet", {busy, reqAck, cacheFetch, cacheInvalidate}, 7'b1000000);
      step();
    end
    dirDataValueReply = 1'b1;
    step();
    dirDataValueReply = 1'b0;
    check("self_inv_ack", reqAck, 2'b01);
    reqReadMiss = 2'b00;
    step();
    $display("self invalidate: cache 0 acked");

    // reset during WAIT_CACHE (lastGrant is 0 here, so reset is what makes cache 0 win next)
    reqWriteMiss = 2'b10;
    step();
    step();
    dirFetch = 1'b1; dirSharers = 2'b01;
    step();
    dirFetch = 1'b0; dirSharers = 2'b00;
    step();
    check("mid_busy_before_reset", busy, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_reset_outputs", outs(), 12'h000);
    clear_inputs();
    step();
    resetn = 1'b1;
    check("mid_reset_no_ack", reqAck, 2'b00);
    reqReadMiss = 2'b11;
    step();
    check("post_reset_grant", {dirReadMiss, dirRequester}, 2'b10);
    step();
    dirDataValueReply = 1'b1;
    step();
    dirDataValueReply = 1'b0;
    check("post_reset_ack", reqAck, 2'b01);
    reqReadMiss = 2'b00;
    step();
    $display("mid-transaction reset: next grant cache 0");

    // randomized traffic against the transaction model
    for (int i = 0; i < 2; i++) begin rq[i] = '0; cool[i] = 0; end
    idle_m = 1'b1; ack_prev = 1'b0; active = 1'b0; last_m = 0; cur = 0; mode = 0;
    ack_due = -1; dir_at = -1; done_at = -1; cmd_due = -1; n_acks = 0; n_grants = 0;
    tgt = '0; cmd_f = '0; cmd_i = '0;
    for (int c = 0; c < 900; c++) begin
      step();
      dirFetch = 1'b0; dirInvalidate = 1'b0; dirDataValueReply = 1'b0;
      dirSharers = '0; cacheDone = '0;
      exp_issue = idle_m && (rq[0] != 3'b000 || rq[1] != 3'b000);
      g = 0;
      exp_msg = 3'b000;
      if (exp_issue) begin
        if (rq[0] != 3'b000 && rq[1] != 3'b000) g = 1 - last_m;
        else g = (rq[1] != 3'b000) ? 1 : 0;
        exp_msg = prio(rq[g]);
      end
      idle_m = exp_issue ? 1'b0 : (ack_prev ? 1'b1 : idle_m);
      check("rnd_msg", {dirWriteBack, dirWriteMiss, dirReadMiss}, exp_msg);
      check("rnd_busy", busy, !idle_m);
      exp_ack = (active && cyc == ack_due) ? (2'b01 << cur) : 2'b00;
      check("rnd_ack", reqAck, exp_ack);
      check("rnd_cmd", {cacheFetch, cacheInvalidate}, (cyc == cmd_due) ? {cmd_f, cmd_i} : 4'b0000);
      ack_prev = 1'b0;
      if (active && cyc == ack_due) begin
        $display("rnd txn %0d: cache %0d acked at cycle %0d", n_acks, cur, cyc);
        active = 1'b0; last_m = cur; rq[cur] = '0; cool[cur] = 2; ack_prev = 1'b1; n_acks++;
      end
      if (exp_issue) begin
        check("rnd_requester", dirRequester, g);
        active = 1'b1; cur = g; n_grants++;
        if (exp_msg == 3'b100) ack_due = cyc + 1;
        else begin
          mode = $urandom_range(0, 2);
          dir_at = cyc + $urandom_range(1, 4);
        end
      end
      if (active && cyc == dir_at) begin
        if (mode == 0) begin
          dirDataValueReply = 1'b1;
          ack_due = cyc + 1;
        end else begin
          fi = 2'($urandom_range(1, 3));
          sh = 2'($urandom_range(0, 3));
          dirFetch = fi[1]; dirInvalidate = fi[0]; dirSharers = sh;
          dirDataValueReply = (mode == 2);
          tgt = sh & ~(2'b01 << cur);
          if (tgt != 2'b00) begin
            cmd_due = cyc + 1;
            cmd_f = fi[1] ? tgt : 2'b00;
            cmd_i = fi[0] ? tgt : 2'b00;
            done_at = cyc + 1 + $urandom_range(1, 4);
          end else if (mode == 2) begin
            ack_due = cyc + 1;
          end else begin
            mode = 0;
            dir_at = cyc + $urandom_range(1, 4);
          end
        end
      end
      if (active && cyc == done_at) begin
        cacheDone = tgt;
        if (mode == 2) ack_due = cyc + 1;
        else begin
          mode = 0;
          dir_at = cyc + $urandom_range(1, 4);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (cool[i] > 0) cool[i]--;
        else if (c < 820 && rq[i] == 3'b000 && $urandom_range(0, 3) == 0)
          rq[i] = 3'($urandom_range(1, 7));
      end
      reqWriteBack = {rq[1][2], rq[0][2]};
      reqWriteMiss = {rq[1][1], rq[0][1]};
      reqReadMiss  = {rq[1][0], rq[0][0]};
    end
    clear_inputs();
    check("rnd_all_acked", n_acks, n_grants);
    check("rnd_enough_txns", n_acks >= 30, 1'b1);
    check("rnd_no_timeout", timeout, 1'b0);

    // silent directory: 15 waiting cycles then abort with ack
    step();
    reqWriteMiss = 2'b01;
    step();
    for (int c = 0; c < 15; c++) step();
    check("to_not_yet", {timeout, reqAck}, 3'b000);
    step();
    check("to_abort", {timeout, reqAck}, 3'b101);
    reqWriteMiss = 2'b00;
    step();
    check("to_sticky_idle", {timeout, busy}, 2'b10);
    reqWriteBack = 2'b10;
    step();
    step();
    check("to_sticky_next_txn", {timeout, reqAck}, 3'b110);
    reqWriteBack = 2'b00;
    step();
    $display("timeout: flag set and held");
    resetn = 1'b0;
    #1;
    check("to_cleared_by_reset", outs(), 12'h000);
    step();
    resetn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
